// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel interval timer:
//   - ch_state_e : per-channel FSM state encoding (IDLE / RUN / DONE)
//   - default widths for channel count, counter width and prescaler width
//   - ch_lsb()   : bit offset of channel n inside a packed per-channel bus
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int PRE_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    // Channel n of a packed bus of w-bit fields lives at [ch_lsb(n, w) +: w].
    function automatic int unsigned ch_lsb(input int unsigned n, input int unsigned w);
        return n * w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
// One interval timer channel: FSM, tick counter, latched interval, sticky
// pending and overrun flags, and the gated interrupt request.
//
// Ports
//   clk         clock, rising edge
//   srst        synchronous active-high reset
//   tick_i      shared prescaler tick (one cycle wide)
//   en_i        run enable (level)
//   interval_i  period in ticks (0 = channel inert)
//   one_shot_i  1 = one-shot, 0 = periodic; captured when the channel starts
//   clr_i       one-cycle clear of pending and overrun
//   irq_en_i    interrupt gate
//   pending_o   sticky expiry flag (ungated)
//   overrun_o   sticky: expiry while pending was already set
//   count_o     current tick count
//   irq_o       pending_o & irq_en_i
// ---------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] interval_i,
    input  logic             one_shot_i,
    input  logic             clr_i,
    input  logic             irq_en_i,
    output logic             pending_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] count_o,
    output logic             irq_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] ival_q,  ival_d;
    logic             mode_q,  mode_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            ival_q    <= '0;
            mode_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ival_q    <= ival_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en_i && (interval_i != '0)) state_d = ST_RUN;
            ST_RUN: begin
                if (!en_i)                state_d = ST_IDLE;
                else if (expire && mode_q) state_d = ST_DONE;
            end
            ST_DONE: if (!en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        // Disabling in RUN takes priority over a coincident tick.
        expire  = (state_q == ST_RUN) && en_i && tick_i &&
                  (count_q == ival_q - 1'b1);
        count_d = count_q;
        ival_d  = ival_q;
        mode_d  = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (en_i && (interval_i != '0)) begin
                    ival_d = interval_i;
                    mode_d = one_shot_i;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    count_d = '0;
                end else if (expire) begin
                    count_d = '0;
                    // Periodic channels pick up a new interval only at the
                    // period boundary, so a mid-period write never truncates.
                    if (!mode_q) ival_d = interval_i;
                end else if (tick_i) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: count_d = '0;
        endcase

        // Expiry beats a coincident clear; overrun needs an uncleared pending.
        pending_d = expire ? 1'b1 : (clr_i ? 1'b0 : pending_q);
        overrun_d = clr_i  ? 1'b0 : (overrun_q | (expire & pending_q));
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign count_o   = count_q;
    assign irq_o     = pending_q & irq_en_i;

endmodule

// File: rtl/multi_interval_timer.sv
// ---------------------------------------------------------------------------
// multi_interval_timer
// NUM_CH independent interval timers sharing one free-running prescaler.
// Per-channel gated interrupts are ORed into interrupt_o.
//
// Ports
//   ap_clk         clock, rising edge
//   ap_rst         synchronous active-high reset
//   prescale_i     tick period minus one (0 = tick every cycle)
//   interval_i     per-channel period in ticks, channel n at [n*CNT_W +: CNT_W]
//   ch_en_i        per-channel run enable
//   one_shot_i     per-channel mode, 1 = one-shot
//   irq_en_i       per-channel interrupt gate
//   irq_clr_i      per-channel clear of pending and overrun
//   irq_pending_o  per-channel sticky expiry flag
//   overrun_o      per-channel sticky overrun flag
//   count_o        per-channel counts (debug)
//   interrupt_o    |(irq_pending_o & irq_en_i)
// ---------------------------------------------------------------------------
module multi_interval_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PRE_W  = PRE_W_DEF
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [PRE_W-1:0]        prescale_i,
    input  logic [NUM_CH*CNT_W-1:0] interval_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH-1:0]       one_shot_i,
    input  logic [NUM_CH-1:0]       irq_en_i,
    input  logic [NUM_CH-1:0]       irq_clr_i,
    output logic [NUM_CH-1:0]       irq_pending_o,
    output logic [NUM_CH-1:0]       overrun_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    interrupt_o
);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic [NUM_CH-1:0] irq_vec;

    // Free-running prescaler. If prescale_i is lowered below pre_q the
    // counter simply runs on and wraps before matching again.
    always_comb begin
        tick  = (pre_q == prescale_i);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            timer_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk        (ap_clk),
                .srst       (ap_rst),
                .tick_i     (tick),
                .en_i       (ch_en_i[gi]),
                .interval_i (interval_i[ch_lsb(gi, CNT_W) +: CNT_W]),
                .one_shot_i (one_shot_i[gi]),
                .clr_i      (irq_clr_i[gi]),
                .irq_en_i   (irq_en_i[gi]),
                .pending_o  (irq_pending_o[gi]),
                .overrun_o  (overrun_o[gi]),
                .count_o    (count_o[ch_lsb(gi, CNT_W) +: CNT_W]),
                .irq_o      (irq_vec[gi])
            );
        end
    endgenerate

    assign interrupt_o = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
module tb_multi_interval_timer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PRE_W  = 16;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst;
    logic [PRE_W-1:0]        prescale_i;
    logic [NUM_CH*CNT_W-1:0] interval_i;
    logic [NUM_CH-1:0]       ch_en_i;
    logic [NUM_CH-1:0]       one_shot_i;
    logic [NUM_CH-1:0]       irq_en_i;
    logic [NUM_CH-1:0]       irq_clr_i;
    logic [NUM_CH-1:0]       irq_pending_o;
    logic [NUM_CH-1:0]       overrun_o;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic                    interrupt_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    multi_interval_timer #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .prescale_i    (prescale_i),
        .interval_i    (interval_i),
        .ch_en_i       (ch_en_i),
        .one_shot_i    (one_shot_i),
        .irq_en_i      (irq_en_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pending_o (irq_pending_o),
        .overrun_o     (overrun_o),
        .count_o       (count_o),
        .interrupt_o   (interrupt_o)
    );

    always #5 ap_clk = ~ap_clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ival(input int n, input logic [CNT_W-1:0] v);
        interval_i[n*CNT_W +: CNT_W] = v;
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int n);
        return count_o[n*CNT_W +: CNT_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-20s observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ap_rst     = 1'b1;
        prescale_i = '0;
        interval_i = '0;
        ch_en_i    = '0;
        one_shot_i = '0;
        irq_en_i   = '0;
        irq_clr_i  = '0;
        steps(2);

        // Reset state
        check("rst_pending", 64'(irq_pending_o), 64'h0);
        check("rst_overrun", 64'(overrun_o), 64'h0);
        check("rst_count", 64'(count_o), 64'h0);
        check("rst_interrupt", 64'(interrupt_o), 64'h0);

        // Periodic, ch0 interval 5, prescale 0
        ap_rst = 1'b0;
        set_ival(0, 16'd5);
        ch_en_i[0]  = 1'b1;
        irq_en_i[0] = 1'b1;
        step();                                   // edge 0: RUN
        check("per_start_count", 64'(cnt(0)), 64'd0);
        steps(4);                                 // edge 4
        check("per_e4_pending", 64'(irq_pending_o[0]), 64'd0);
        check("per_e4_count", 64'(cnt(0)), 64'd4);
        step();                                   // edge 5
        check("per_e5_pending", 64'(irq_pending_o[0]), 64'd1);
        check("per_e5_irq", 64'(interrupt_o), 64'd1);
        irq_clr_i[0] = 1'b1;
        step();                                   // edge 6
        irq_clr_i[0] = 1'b0;
        check("per_e6_cleared", 64'(irq_pending_o[0]), 64'd0);
        irq_en_i[0] = 1'b0;
        steps(4);                                 // edge 10
        check("per_e10_pending", 64'(irq_pending_o[0]), 64'd1);
        check("per_gated_irq", 64'(interrupt_o), 64'd0);
        irq_en_i[0] = 1'b1;
        #1;
        check("per_ungated_irq", 64'(interrupt_o), 64'd1);
        ch_en_i[0]   = 1'b0;
        irq_clr_i[0] = 1'b1;
        step();
        irq_clr_i[0] = 1'b0;
        irq_en_i     = '0;
        check("per_off_count", 64'(cnt(0)), 64'd0);
        check("per_off_pending", 64'(irq_pending_o[0]), 64'd0);

        // One-shot, ch1 interval 3
        set_ival(1, 16'd3);
        one_shot_i[1] = 1'b1;
        ch_en_i[1]    = 1'b1;
        step();                                   // edge 0
        steps(2);                                 // edge 2
        check("os_e2_pending", 64'(irq_pending_o[1]), 64'd0);
        step();                                   // edge 3
        check("os_e3_pending", 64'(irq_pending_o[1]), 64'd1);
        irq_clr_i[1] = 1'b1;
        step();                                   // edge 4
        irq_clr_i[1] = 1'b0;
        steps(16);                                // edge 20
        check("os_e20_no_reexp", 64'(irq_pending_o[1]), 64'd0);
        check("os_e20_count", 64'(cnt(1)), 64'd0);
        ch_en_i[1] = 1'b0;
        step();
        ch_en_i[1] = 1'b1;
        step();                                   // restart sampled
        steps(2);
        check("os_re_e2_pending", 64'(irq_pending_o[1]), 64'd0);
        step();
        check("os_re_e3_pending", 64'(irq_pending_o[1]), 64'd1);
        ch_en_i[1]   = 1'b0;
        irq_clr_i[1] = 1'b1;
        step();
        irq_clr_i[1]  = 1'b0;
        one_shot_i[1] = 1'b0;

        // Overrun and simultaneous clear, ch2 interval 2
        set_ival(2, 16'd2);
        ch_en_i[2] = 1'b1;
        step();                                   // edge 0
        steps(2);                                 // edge 2
        check("ov_e2_pending", 64'(irq_pending_o[2]), 64'd1);
        check("ov_e2_overrun", 64'(overrun_o[2]), 64'd0);
        steps(2);                                 // edge 4
        check("ov_e4_overrun", 64'(overrun_o[2]), 64'd1);
        irq_clr_i[2] = 1'b1;
        step();                                   // edge 5
        irq_clr_i[2] = 1'b0;
        check("ov_e5_pending", 64'(irq_pending_o[2]), 64'd0);
        check("ov_e5_overrun", 64'(overrun_o[2]), 64'd0);
        step();                                   // edge 6
        check("ov_e6_pending", 64'(irq_pending_o[2]), 64'd1);
        step();                                   // edge 7
        irq_clr_i[2] = 1'b1;
        step();                                   // edge 8: expiry + clear
        irq_clr_i[2] = 1'b0;
        check("sim_pending", 64'(irq_pending_o[2]), 64'd1);
        check("sim_overrun", 64'(overrun_o[2]), 64'd0);
        ch_en_i[2]   = 1'b0;
        irq_clr_i[2] = 1'b1;
        step();
        irq_clr_i[2] = 1'b0;

        // Interval 0 is inert; interval 1 expires every tick (ch3)
        set_ival(3, 16'd0);
        ch_en_i[3] = 1'b1;
        steps(3);
        check("iv0_count", 64'(cnt(3)), 64'd0);
        check("iv0_pending", 64'(irq_pending_o[3]), 64'd0);
        set_ival(3, 16'd1);
        step();                                   // edge 0
        check("iv1_e0_pending", 64'(irq_pending_o[3]), 64'd0);
        step();                                   // edge 1
        check("iv1_e1_pending", 64'(irq_pending_o[3]), 64'd1);
        irq_clr_i[3] = 1'b1;
        step();                                   // edge 2
        irq_clr_i[3] = 1'b0;
        check("iv1_e2_pending", 64'(irq_pending_o[3]), 64'd1);
        check("iv1_e2_overrun", 64'(overrun_o[3]), 64'd0);
        step();                                   // edge 3
        check("iv1_e3_overrun", 64'(overrun_o[3]), 64'd1);
        ch_en_i[3]   = 1'b0;
        irq_clr_i[3] = 1'b1;
        step();
        irq_clr_i[3] = 1'b0;

        // Interval change mid-period 4 -> 6 (ch0)
        set_ival(0, 16'd4);
        ch_en_i[0] = 1'b1;
        step();                                   // edge 0
        steps(2);                                 // edge 2
        check("chg_e2_count", 64'(cnt(0)), 64'd2);
        set_ival(0, 16'd6);
        steps(2);                                 // edge 4
        check("chg_e4_pending", 64'(irq_pending_o[0]), 64'd1);
        irq_clr_i[0] = 1'b1;
        step();                                   // edge 5
        irq_clr_i[0] = 1'b0;
        steps(3);                                 // edge 8
        check("chg_e8_pending", 64'(irq_pending_o[0]), 64'd0);
        check("chg_e8_count", 64'(cnt(0)), 64'd4);
        steps(2);                                 // edge 10
        check("chg_e10_pending", 64'(irq_pending_o[0]), 64'd1);
        ch_en_i[0] = 1'b0;

        // Prescaler 3, interval 2, enabled right after reset
        ap_rst = 1'b1;
        step();
        prescale_i = 16'd3;
        set_ival(0, 16'd2);
        ch_en_i[0] = 1'b1;
        ap_rst     = 1'b0;
        step();                                   // edge 0
        steps(6);                                 // edge 6
        check("pre_e6_pending", 64'(irq_pending_o[0]), 64'd0);
        step();                                   // edge 7
        check("pre_e7_pending", 64'(irq_pending_o[0]), 64'd1);
        irq_clr_i[0] = 1'b1;
        step();                                   // edge 8
        irq_clr_i[0] = 1'b0;
        steps(6);                                 // edge 14
        check("pre_e14_pending", 64'(irq_pending_o[0]), 64'd0);
        step();                                   // edge 15
        check("pre_e15_pending", 64'(irq_pending_o[0]), 64'd1);

        // Reset mid-operation with two channels running and pending
        ch_en_i    = '0;
        ap_rst     = 1'b1;
        prescale_i = '0;
        step();
        ap_rst = 1'b0;
        set_ival(0, 16'd3);
        set_ival(1, 16'd3);
        ch_en_i  = 4'b0011;
        irq_en_i = 4'b0011;
        step();                                   // edge 0
        steps(3);                                 // edge 3
        check("rm_pending", 64'(irq_pending_o), 64'h3);
        check("rm_irq", 64'(interrupt_o), 64'd1);
        step();                                   // edge 4
        check("rm_count_before", 64'(cnt(0)), 64'd1);
        ap_rst = 1'b1;
        step();
        check("rm_rst_pending", 64'(irq_pending_o), 64'h0);
        check("rm_rst_count", 64'(count_o), 64'h0);
        check("rm_rst_irq", 64'(interrupt_o), 64'd0);
        check("rm_rst_overrun", 64'(overrun_o), 64'h0);
        ap_rst = 1'b0;
        step();                                   // edge 0: restart
        step();                                   // edge 1
        check("rm_restart_count", 64'(cnt(0)), 64'd1);
        steps(2);                                 // edge 3
        check("rm_restart_pending", 64'(irq_pending_o), 64'h3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
